// File: rtl/gen_arb_pkg.sv
// rtl/gen_arb_pkg.sv - shared FSM state type and default sizing for gen_arbiter
package gen_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int NREQ_DEF   = 4;
  localparam int LEN_W_DEF  = 4;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, search starts just after i_ptr
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    // k runs 1..NREQ so the current pointer holder is checked last
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/gen_arbiter.sv
// rtl/gen_arbiter.sv - round-robin burst arbiter owning a shared 8-bit data generator
// Optional macro GEN_ARB_BURST_CLR_EN: clear the data counter at every arbitration.
module gen_arbiter
  import gen_arb_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] burst_len,
  input  logic                  ready,
  output logic [NREQ-1:0]       grant,
  output logic [DATA_W-1:0]     data_out,
  output logic                  valid,
  output logic                  last,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREQ-1:0]  r_grant;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;
  logic [LEN_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_data;

  logic [NREQ-1:0]  w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_arb;
  logic             w_xfer;
  logic             w_end;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_arb  = (r_state == ST_IDLE) && (|req);
  assign w_xfer = (r_state == ST_BURST) && ready;
  assign w_end  = w_xfer && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb) w_state_nxt = ST_BURST;
      ST_BURST: if (w_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // r_cnt holds remaining beats minus one, so zero marks the last beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      if (w_arb) begin
        r_grant <= w_onehot;
        r_idx   <= w_idx;
        r_cnt   <= burst_len[int'(w_idx)*LEN_W +: LEN_W];
`ifdef GEN_ARB_BURST_CLR_EN
        r_data  <= '0;
`endif
      end
      if (w_xfer) begin
        r_data <= r_data + DATA_W'(1);
        if (w_end) begin
          r_grant <= '0;
          r_ptr   <= r_idx;
        end else begin
          r_cnt <= r_cnt - LEN_W'(1);
        end
      end
    end
  end

  assign grant    = r_grant;
  assign data_out = r_data;
  assign valid    = (r_state == ST_BURST);
  assign last     = (r_state == ST_BURST) && (r_cnt == '0);
  assign busy     = |r_grant;

endmodule

// File: tb/tb_gen_arbiter.sv
// tb/tb_gen_arbiter.sv - scoreboard bench for gen_arbiter against a burst-level reference model
module tb_gen_arbiter;

  localparam int NREQ   = 4;
  localparam int LEN_W  = 4;
  localparam int DATA_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] burst_len;
  logic                  ready;
  logic [NREQ-1:0]       grant;
  logic [DATA_W-1:0]     data_out;
  logic                  valid;
  logic                  last;
  logic                  busy;

  gen_arbiter #(
    .NREQ   (NREQ),
    .LEN_W  (LEN_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .burst_len (burst_len),
    .ready     (ready),
    .grant     (grant),
    .data_out  (data_out),
    .valid     (valid),
    .last      (last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]   g;
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
  endtask

  // Reference model: a burst is a list of expected beats pushed when it is won
  bit m_busy    = 1'b0;
  bit m_was_rst = 1'b0;
  int m_ptr     = NREQ - 1;
  int m_rem     = 0;
  int m_win     = 0;
  int m_data    = 0;

  always @(posedge clk) begin
    m_was_rst = rst;
    if (rst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_ptr  = NREQ - 1;
      m_data = 0;
    end else if (!m_busy) begin
      if (req != '0) begin
        int len;
        m_win = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (m_win < 0 && req[c]) m_win = c;
        end
        len = int'(burst_len[m_win*LEN_W +: LEN_W]);
`ifdef GEN_ARB_BURST_CLR_EN
        m_data = 0;
`endif
        for (int b = 0; b <= len; b++) begin
          beat_t e;
          e.g = NREQ'(1 << m_win);
          e.d = DATA_W'(m_data);
          e.l = (b == len);
          exp_q.push_back(e);
          m_data = (m_data + 1) % (1 << DATA_W);
        end
        m_busy = 1'b1;
        m_rem  = len + 1;
      end
    end else if (ready) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        m_ptr  = m_win;
      end
    end
  end

  // Monitor: head of queue must be presented every valid cycle, popped on transfer
  always @(negedge clk) begin
    if (m_was_rst) chk(data_out == '0, "reset_data", 32'(data_out), 0);
    chk(valid == m_busy, "valid", 32'(valid), 32'(m_busy));
    chk(busy == (grant != '0), "busy", 32'(busy), 32'(grant != '0));
    if (!valid) begin
      chk({grant, last} == '0, "idle_outputs", 32'({grant, last}), 0);
    end else if (exp_q.size() == 0) begin
      chk(1'b0, "unexpected_beat", 32'({grant, data_out, last}), 0);
    end else begin
      chk({grant, data_out, last} == exp_q[0], "beat", 32'({grant, data_out, last}), 32'(exp_q[0]));
      if (ready) void'(exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; burst_len = '0; ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);

    // single 4-beat burst from requester 0
    req = 4'b0001; burst_len = 16'h0003; ready = 1'b1;
    step(1);
    req = '0;
    step(6);

    // alternating single-beat bursts between requesters 0 and 2
    req = 4'b0101; burst_len = '0;
    step(6);
    req = '0;
    step(2);

    // backpressure on a 4-beat burst
    req = 4'b0010; burst_len = 16'h0030;
    step(1);
    req = '0;
    step(2);
    ready = 1'b0;
    step(3);
    ready = 1'b1;
    step(5);

    // reset during requester 2's burst, then requesters 1 and 3 compete
    req = 4'b0100; burst_len = 16'h0300;
    step(2);
    req = '0; rst = 1'b1;
    step(1);
    rst = 1'b0; req = 4'b1010; burst_len = 16'h2020;
    step(10);

    // randomized traffic, long enough for the counter to wrap many times
    for (int i = 0; i < 3000; i++) begin
      req       = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom);
      burst_len = (NREQ*LEN_W)'($urandom);
      ready     = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      step(1);
    end

    rst = 1'b0; req = '0; ready = 1'b1;
    step(40);
    chk(exp_q.size() == 0, "drain_queue", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
